// File: rtl/ps_ureg_file.sv
// ps_ureg_file: program-sequencer universal register bank.
// Holds CNTR (01), MODE (02), the PC/status hardware stack (04) and the
// stack status register SSTAT (05). The read path is combinational. There is
// no write-to-read bypass: a read in the same cycle as a write returns the old value.
// Optional feature: define PS_STK_ERR_INT_EN to enable the registered
// one-cycle stack-error pulse on ps_stk_int. When it is undefined, the output is tied to 0.
module ps_ureg_file #(
    parameter int DATA_W    = 16,
    parameter int STK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ps_wrt_en,
    input  logic [4:0]        ps_wrt_add,
    input  logic [DATA_W-1:0] ps_wrt_data,
    input  logic [4:0]        ps_rd_add,
    input  logic              ps_popstck,
    input  logic              ps_cntr_dec,
    output logic [DATA_W-1:0] ps_rd_data,
    output logic              ps_cntr_exp,
    output logic              ps_stk_empty,
    output logic              ps_stk_full,
    output logic              ps_stk_int
);
    localparam int AW = $clog2(STK_DEPTH);
    localparam int DW = $clog2(STK_DEPTH) + 1;

    localparam logic [4:0] A_CNTR  = 5'h01;
    localparam logic [4:0] A_MODE  = 5'h02;
    localparam logic [4:0] A_STK   = 5'h04;
    localparam logic [4:0] A_SSTAT = 5'h05;

    logic [DATA_W-1:0] cntr_q, cntr_d;
    logic [DATA_W-1:0] mode_q, mode_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              exp_q, exp_d;

    logic [DATA_W-1:0] stk_mem [STK_DEPTH];

    logic              push, pop, wr_cntr, wr_mode, wr_sstat;
    logic              stk_empty, stk_full;
    logic [AW-1:0]     top_idx;
    logic [DATA_W-1:0] top_data;
    logic              mem_we;
    logic [AW-1:0]     mem_idx;
    logic              ovf_set, unf_set;
    logic [DATA_W-1:0] sstat;

    // Decode the write strobes and derive the stack status from depth.
    always_comb begin
        push      = ps_wrt_en && (ps_wrt_add == A_STK);
        wr_cntr   = ps_wrt_en && (ps_wrt_add == A_CNTR);
        wr_mode   = ps_wrt_en && (ps_wrt_add == A_MODE);
        wr_sstat  = ps_wrt_en && (ps_wrt_add == A_SSTAT);
        pop       = ps_popstck;
        stk_empty = (depth_q == '0);
        stk_full  = (depth_q == DW'(STK_DEPTH));
        // Depth is a power of two, so wrap-around at depth==STK_DEPTH lands on the last entry.
        top_idx   = depth_q[AW-1:0] - AW'(1);
        top_data  = stk_mem[top_idx];
    end

    // Stack next-state: push, pop, replace-top and the error events.
    always_comb begin
        depth_d = depth_q;
        mem_we  = 1'b0;
        mem_idx = depth_q[AW-1:0];
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (push && pop) begin
            mem_we = 1'b1;
            if (stk_empty) begin
                // Pop on empty together with a push degenerates into a plain push.
                mem_idx = '0;
                depth_d = DW'(1);
            end else begin
                mem_idx = top_idx;
            end
        end else if (push) begin
            if (stk_full) begin
                ovf_set = 1'b1;
            end else begin
                mem_we  = 1'b1;
                depth_d = depth_q + DW'(1);
            end
        end else if (pop) begin
            if (stk_empty) begin
                unf_set = 1'b1;
            end else begin
                depth_d = depth_q - DW'(1);
            end
        end
    end

    // Sticky error bits: a new event wins over a same-cycle write-1-to-clear.
    always_comb begin
        ovf_d = (ovf_q & ~(wr_sstat & ps_wrt_data[2])) | ovf_set;
        unf_d = (unf_q & ~(wr_sstat & ps_wrt_data[3])) | unf_set;
    end

    // CNTR and MODE. A CNTR write beats a decrement, and the counter saturates at zero.
    always_comb begin
        cntr_d = cntr_q;
        exp_d  = exp_q;
        mode_d = wr_mode ? ps_wrt_data : mode_q;
        if (wr_cntr) begin
            cntr_d = ps_wrt_data;
            exp_d  = 1'b0;
        end else if (ps_cntr_dec) begin
            if (cntr_q != '0) begin
                cntr_d = cntr_q - DATA_W'(1);
            end
            exp_d = (cntr_q == DATA_W'(1));
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntr_q  <= '0;
            mode_q  <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            cntr_q  <= cntr_d;
            mode_q  <= mode_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            exp_q   <= exp_d;
        end
    end

    // Stack storage. Its contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            stk_mem[mem_idx] <= ps_wrt_data;
        end
    end

    // Combinational read mux. Unmapped addresses read zero.
    always_comb begin
        sstat          = '0;
        sstat[0]       = stk_empty;
        sstat[1]       = stk_full;
        sstat[2]       = ovf_q;
        sstat[3]       = unf_q;
        sstat[4 +: DW] = depth_q;
        case (ps_rd_add)
            A_CNTR:  ps_rd_data = cntr_q;
            A_MODE:  ps_rd_data = mode_q;
            A_STK:   ps_rd_data = stk_empty ? '0 : top_data;
            A_SSTAT: ps_rd_data = sstat;
            default: ps_rd_data = '0;
        endcase
    end

    assign ps_cntr_exp  = exp_q;
    assign ps_stk_empty = stk_empty;
    assign ps_stk_full  = stk_full;

`ifdef PS_STK_ERR_INT_EN
    logic stk_int_q, stk_int_d;

    // One-cycle error pulse, registered on the edge of the offending operation.
    always_comb begin
        stk_int_d = ovf_set | unf_set;
    end

    // Error pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_int_q <= 1'b0;
        end else begin
            stk_int_q <= stk_int_d;
        end
    end

    assign ps_stk_int = stk_int_q;
`else
    assign ps_stk_int = 1'b0;
`endif

endmodule

// File: tb/tb_ps_ureg_file.sv
// Self-checking bench for ps_ureg_file: expected values are queued when stimulus
// is applied and popped/compared against the DUT outputs they refer to.
module tb_ps_ureg_file;
    localparam int DATA_W = 16;

    localparam int K_RD    = 0;
    localparam int K_EXP   = 1;
    localparam int K_EMPTY = 2;
    localparam int K_FULL  = 3;
    localparam int K_INT   = 4;

`ifdef PS_STK_ERR_INT_EN
    localparam logic [15:0] INT_EXP = 16'h0001;
`else
    localparam logic [15:0] INT_EXP = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ps_wrt_en;
    logic [4:0]        ps_wrt_add;
    logic [DATA_W-1:0] ps_wrt_data;
    logic [4:0]        ps_rd_add;
    logic              ps_popstck;
    logic              ps_cntr_dec;
    logic [DATA_W-1:0] ps_rd_data;
    logic              ps_cntr_exp;
    logic              ps_stk_empty;
    logic              ps_stk_full;
    logic              ps_stk_int;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [15:0] exp;
    } sb_t;
    sb_t sb_q[$];

    ps_ureg_file #(.DATA_W(DATA_W), .STK_DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps_wrt_en    (ps_wrt_en),
        .ps_wrt_add   (ps_wrt_add),
        .ps_wrt_data  (ps_wrt_data),
        .ps_rd_add    (ps_rd_add),
        .ps_popstck   (ps_popstck),
        .ps_cntr_dec  (ps_cntr_dec),
        .ps_rd_data   (ps_rd_data),
        .ps_cntr_exp  (ps_cntr_exp),
        .ps_stk_empty (ps_stk_empty),
        .ps_stk_full  (ps_stk_full),
        .ps_stk_int   (ps_stk_int)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    function automatic logic [15:0] obs_of(input int kind);
        case (kind)
            K_RD:    return ps_rd_data;
            K_EXP:   return {15'd0, ps_cntr_exp};
            K_EMPTY: return {15'd0, ps_stk_empty};
            K_FULL:  return {15'd0, ps_stk_full};
            default: return {15'd0, ps_stk_int};
        endcase
    endfunction

    task automatic sb_exp(input string tag, input int kind, input logic [15:0] exp);
        sb_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then compare everything queued.
    task automatic sb_drain();
        sb_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, obs_of(e.kind), e.exp);
        end
    endtask

    task automatic do_rd(input logic [4:0] addr, input logic [15:0] exp, input string tag);
        ps_rd_add = addr;
        sb_exp(tag, K_RD, exp);
        sb_drain();
    endtask

    task automatic do_wr(input logic [4:0] addr, input logic [15:0] data);
        ps_wrt_en   = 1'b1;
        ps_wrt_add  = addr;
        ps_wrt_data = data;
        @(posedge clk);
        #1;
        ps_wrt_en = 1'b0;
    endtask

    task automatic do_pop(input logic [15:0] exp, input string tag);
        ps_rd_add  = 5'h04;
        ps_popstck = 1'b1;
        sb_exp(tag, K_RD, exp);
        sb_drain();
        @(posedge clk);
        #1;
        ps_popstck = 1'b0;
    endtask

    task automatic do_dec(input logic [15:0] cntr_exp, input logic exp_flag, input string tag);
        ps_cntr_dec = 1'b1;
        @(posedge clk);
        #1;
        ps_cntr_dec = 1'b0;
        ps_rd_add   = 5'h01;
        sb_exp({tag, "_cntr"}, K_RD, cntr_exp);
        sb_exp({tag, "_exp"}, K_EXP, {15'd0, exp_flag});
        sb_drain();
    endtask

    initial begin
        rst_n       = 1'b0;
        ps_wrt_en   = 1'b0;
        ps_wrt_add  = '0;
        ps_wrt_data = '0;
        ps_rd_add   = '0;
        ps_popstck  = 1'b0;
        ps_cntr_dec = 1'b0;

        // Reset state
        #12;
        do_rd(5'h01, 16'h0000, "rst_cntr");
        do_rd(5'h02, 16'h0000, "rst_mode");
        do_rd(5'h05, 16'h0001, "rst_sstat");
        sb_exp("rst_empty", K_EMPTY, 16'h1);
        sb_exp("rst_full", K_FULL, 16'h0);
        sb_exp("rst_exp", K_EXP, 16'h0);
        sb_exp("rst_int", K_INT, 16'h0);
        sb_drain();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three pushes, peek, three pops
        do_wr(5'h04, 16'h1111);
        do_wr(5'h04, 16'h2222);
        do_wr(5'h04, 16'h3333);
        do_rd(5'h04, 16'h3333, "peek3");
        do_rd(5'h05, 16'h0030, "sstat_d3");
        do_pop(16'h3333, "pop_a");
        do_pop(16'h2222, "pop_b");
        do_pop(16'h1111, "pop_c");
        do_rd(5'h05, 16'h0001, "sstat_empty");

        // Overflow: nine pushes into eight entries
        for (int i = 0; i < 8; i++) do_wr(5'h04, 16'h1000 + 16'(i));
        sb_exp("full_8", K_FULL, 16'h1);
        sb_exp("int_none", K_INT, 16'h0);
        sb_drain();
        do_wr(5'h04, 16'h1008);
        sb_exp("int_ovf", K_INT, INT_EXP);
        sb_drain();
        do_rd(5'h05, 16'h0086, "sstat_ovf");
        do_rd(5'h04, 16'h1007, "peek_after_ovf");
        @(posedge clk);
        #1;
        sb_exp("int_ovf_off", K_INT, 16'h0);
        sb_drain();
        do_wr(5'h05, 16'h0004);
        do_rd(5'h05, 16'h0082, "sstat_ovf_clr");
        for (int i = 7; i >= 0; i--) do_pop(16'h1000 + 16'(i), $sformatf("pop_full_%0d", i));

        // Underflow on empty
        do_pop(16'h0000, "pop_empty");
        sb_exp("int_unf", K_INT, INT_EXP);
        sb_drain();
        do_rd(5'h05, 16'h0009, "sstat_unf");
        // Underflow with a simultaneous W1C of UNF: the set wins
        ps_wrt_en   = 1'b1;
        ps_wrt_add  = 5'h05;
        ps_wrt_data = 16'h0008;
        do_pop(16'h0000, "pop_empty_w1c");
        ps_wrt_en = 1'b0;
        do_rd(5'h05, 16'h0009, "sstat_unf_set_wins");
        do_wr(5'h05, 16'h0008);
        do_rd(5'h05, 16'h0001, "sstat_unf_clr");

        // Push and pop together on empty: acts as a push
        ps_wrt_en   = 1'b1;
        ps_wrt_add  = 5'h04;
        ps_wrt_data = 16'h5A5A;
        do_pop(16'h0000, "pushpop_empty_rd");
        ps_wrt_en = 1'b0;
        do_rd(5'h05, 16'h0010, "sstat_pushpop_empty");
        do_rd(5'h04, 16'h5A5A, "peek_pushpop_empty");

        // Push and pop together at depth 2: replace the top entry
        do_wr(5'h04, 16'hAAAA);
        ps_wrt_en   = 1'b1;
        ps_wrt_add  = 5'h04;
        ps_wrt_data = 16'hBBBB;
        do_pop(16'hAAAA, "replace_rd");
        ps_wrt_en = 1'b0;
        do_rd(5'h05, 16'h0020, "sstat_replace");
        do_rd(5'h04, 16'hBBBB, "peek_replace");
        do_pop(16'hBBBB, "pop_r1");
        do_pop(16'h5A5A, "pop_r2");

        // Counter decrement and expiry
        do_wr(5'h01, 16'h0002);
        do_rd(5'h01, 16'h0002, "cntr_wr");
        do_dec(16'h0001, 1'b0, "dec1");
        do_dec(16'h0000, 1'b1, "dec2");
        do_dec(16'h0000, 1'b0, "dec3");
        // A write beats a decrement and clears expiry
        do_wr(5'h01, 16'h0001);
        do_dec(16'h0000, 1'b1, "dec_to_exp");
        ps_cntr_dec = 1'b1;
        do_wr(5'h01, 16'h0003);
        ps_cntr_dec = 1'b0;
        ps_rd_add = 5'h01;
        sb_exp("wr_over_dec_cntr", K_RD, 16'h0003);
        sb_exp("wr_over_dec_exp", K_EXP, 16'h0000);
        sb_drain();

        // MODE read-during-write returns the old value
        do_wr(5'h02, 16'hBEEF);
        ps_wrt_en   = 1'b1;
        ps_wrt_add  = 5'h02;
        ps_wrt_data = 16'h1234;
        do_rd(5'h02, 16'hBEEF, "mode_rdw_old");
        @(posedge clk);
        #1;
        ps_wrt_en = 1'b0;
        do_rd(5'h02, 16'h1234, "mode_new");

        // Unmapped addresses
        do_wr(5'h03, 16'hFFFF);
        do_rd(5'h03, 16'h0000, "unmapped_03");
        do_rd(5'h1F, 16'h0000, "unmapped_1f");

        // Asynchronous reset mid-sequence, with no clock edge
        for (int i = 0; i < 5; i++) do_wr(5'h04, 16'h2000 + 16'(i));
        do_wr(5'h01, 16'h0007);
        do_rd(5'h05, 16'h0050, "sstat_d5");
        @(negedge clk);
        ps_wrt_en   = 1'b1;
        ps_wrt_add  = 5'h04;
        ps_wrt_data = 16'h7777;
        #1;
        rst_n = 1'b0;
        do_rd(5'h05, 16'h0001, "arst_sstat");
        do_rd(5'h01, 16'h0000, "arst_cntr");
        do_rd(5'h02, 16'h0000, "arst_mode");
        sb_exp("arst_empty", K_EMPTY, 16'h1);
        sb_exp("arst_full", K_FULL, 16'h0);
        sb_drain();
        ps_wrt_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_rd(5'h05, 16'h0001, "post_rst_sstat");

        if (sb_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_leftover: got %0d entries, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ps_ureg_file.md
# ps_ureg_file

Program-sequencer universal register bank with an integrated hardware stack. It sits directly downstream of the PS universal-register address decoder. It consumes the decoder's registered write enable and address and its combinational read address. It also takes the push/pop strobes and data, and returns read data to the universal-register transfer bus. It holds the loop counter, the mode register, the PC/status stack (address 5'h04) and the stack status register.

## Interface
- DATA_W, 16: width of every register and stack entry.
- STK_DEPTH, 8: stack entries, power of two, 2..16.
- clk  in  1  PS clock.
- rst_n  in  1  Asynchronous active-low reset.
- ps_wrt_en  in  1  Registered write enable from the decoder.
- ps_wrt_add  in  5  Registered write address.
- ps_wrt_data  in  DATA_W  Write data, aligned with ps_wrt_en.
- ps_rd_add  in  5  Combinational read address.
- ps_popstck  in  1  Pop strobe, same cycle as ps_rd_add=5'h04.
- ps_cntr_dec  in  1  Decrement loop counter.
- ps_rd_data  out  DATA_W  Combinational read data.
- ps_cntr_exp  out  1  Counter expiry flag, registered.
- ps_stk_empty  out  1  Stack empty.
- ps_stk_full  out  1  Stack full.
- ps_stk_int  out  1  One-cycle stack-error pulse (see Configuration).

## Operation
- Address map (low 5 bits):
  - 01: CNTR, read/write.
  - 02: MODE, read/write.
  - 04: STACK, write=push, read=top.
  - 05: SSTAT, read / write-1-to-clear.
  - Every other address reads 0; writes to it are ignored.
- SSTAT bit layout:
  - bit0: empty.
  - bit1: full.
  - bit2: OVF (sticky).
  - bit3: UNF (sticky).
  - bits[8:4]: depth, zero-extended.
  - Upper bits read 0.
  - A write clears OVF/UNF where the data bit is 1. Other bits are read-only.
- Stack storage is an array of STK_DEPTH entries plus a depth counter of width $clog2(STK_DEPTH)+1.
- Push (ps_wrt_en and add=04):
  - If not full, store data at the top and increment depth.
  - If full, drop the data, leave depth unchanged, set OVF.
- Pop (ps_popstck):
  - If not empty, decrement depth. ps_rd_data shows the pre-pop top in the same cycle.
  - If empty, ps_rd_data=0 and UNF is set.
- Reading 04 without ps_popstck is a non-destructive peek. Reading 04 when empty returns 0.
- Push and pop in the same cycle:
  - Not empty: replace the top entry with the new data; depth unchanged; no flags.
  - Empty: acts as a push only (depth becomes 1); UNF is not set.
- CNTR: ps_cntr_dec decrements the counter, saturating at 0.
  - A CNTR write in the same cycle takes priority over the decrement.
  - ps_cntr_exp is set on the edge where a decrement moves CNTR from 1 to 0.
  - ps_cntr_exp is cleared by any CNTR write or by the next decrement.
- Read-during-write to the same address returns the old value. There is no bypass.

## Timing
- Reset values:
  - CNTR, MODE, OVF, UNF, depth, ps_cntr_exp and ps_stk_int = 0.
  - ps_stk_empty = 1, ps_stk_full = 0.
  - Stack contents are don't-care.
- Reset is asynchronous: asserting rst_n mid-push or mid-pop discards the operation.
- Write latency: data is visible on ps_rd_data one cycle after ps_wrt_en.
- Read path is purely combinational from ps_rd_add and state.
- empty/full are decoded combinationally from depth and update on the edge that changes depth.
- OVF/UNF set on the edge of the offending operation.
  - A set in the same cycle as a W1C write to the same bit wins.

## Configuration
- PS_STK_ERR_INT_EN defined: ps_stk_int pulses high for exactly one cycle, registered, on the edge after any overflow or underflow event.
  - Consecutive errors give consecutive pulses.
- PS_STK_ERR_INT_EN undefined: ps_stk_int is tied to 0 and its logic is absent. OVF/UNF sticky bits behave identically either way.

## Test plan
- Push 0x1111, 0x2222, 0x3333 to 04, then pop three times -> reads 0x3333, 0x2222, 0x1111; SSTAT then reads 0x0001.
- Push 9 values with STK_DEPTH=8 -> full=1, ninth value dropped, SSTAT=0x0086. With macro defined, ps_stk_int pulses once. Write 0x0004 to 05 -> OVF cleared.
- Pop on empty stack -> ps_rd_data=0, UNF=1, depth stays 0. Push and pop in the same cycle on empty -> depth=1, top equals pushed data.
- With depth 2 and top 0xAAAA, push 0xBBBB and pop in the same cycle -> read shows 0xAAAA, depth stays 2, peek then returns 0xBBBB.
- Write CNTR=2, then assert ps_cntr_dec for 3 cycles -> CNTR goes 1, 0, 0; ps_cntr_exp=1 after the second decrement and cleared after the third.
- Assert rst_n low mid-sequence with depth 5 and CNTR=7 -> all registers return to reset values immediately, asynchronously, with no clock edge required.
